lmi_watch_ctl: RTL and testbench

LMI_WATCH_CTL -- requirements
Module: lmi_watch_ctl

---
 rtl/lmi_watch_ctl_pkg.sv | 20 ++
 rtl/lmi_watch_cmp.sv | 21 ++
 rtl/watch_symbols.vh | 38 +++
 rtl/lmi_watch_ctl.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_lmi_watch_ctl.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/lmi_watch_ctl_pkg.sv
// Package for the LMI watchpoint controller.
// Pulls in the shared symbol table and defines the FSM state type plus a
// small helper for the hit-count threshold.
package lmi_watch_ctl_pkg;

`include "watch_symbols.vh"

    typedef enum logic [1:0] {
        ST_IDLE   = ST_ENC_IDLE,
        ST_ARMED  = ST_ENC_ARMED,
        ST_PEND   = ST_ENC_PEND,
        ST_HALTED = ST_ENC_HALTED
    } watch_state_e;

    // A programmed threshold of zero behaves like one: the first hit halts.
    function automatic logic [7:0] eff_thresh(input logic [7:0] thresh);
        return (thresh == 8'd0) ? 8'd1 : thresh;
    endfunction

endpackage

// File: rtl/lmi_watch_cmp.sv
// Masked address comparator for the LMI watchpoint controller.
// match is high when every address bit not masked off equals the watch
// address; a mask bit of 1 makes that bit a don't-care.
// Ports:
//   addr  [31:0] in  - address under test
//   watch [31:0] in  - programmed watch address
//   mask  [31:0] in  - don't-care mask
//   match        out - combinational match result
module lmi_watch_cmp (
    input  logic [31:0] addr,
    input  logic [31:0] watch,
    input  logic [31:0] mask,
    output logic        match
);

    // Bitwise masked equality
    always_comb begin
        match = (((addr ^ watch) & ~mask) == 32'd0);
    end

endmodule

// File: rtl/watch_symbols.vh
// Shared symbol table for the LMI watchpoint controller.
// Holds the debug register select codes, CTRL/STATUS bit positions and
// the FSM state encodings. Included inside lmi_watch_ctl_pkg so every
// user sees the same values through the package import.
`ifndef WATCH_SYMBOLS_VH
`define WATCH_SYMBOLS_VH

// Debug register select codes (DBG_SEL)
localparam logic [2:0] SEL_CTRL   = 3'd0;
localparam logic [2:0] SEL_IADDR  = 3'd1;
localparam logic [2:0] SEL_IMASK  = 3'd2;
localparam logic [2:0] SEL_DADDR  = 3'd3;
localparam logic [2:0] SEL_DMASK  = 3'd4;
localparam logic [2:0] SEL_STATUS = 3'd5;
localparam logic [2:0] SEL_THRESH = 3'd6;
localparam logic [2:0] SEL_RSVD   = 3'd7;

// CTRL bit positions; RESUME is write-only and never stored
localparam int CTRL_W      = 4;
localparam int CTRL_IW_EN  = 0;
localparam int CTRL_DW_EN  = 1;
localparam int CTRL_DW_RD  = 2;
localparam int CTRL_DW_WR  = 3;
localparam int CTRL_RESUME = 8;

// STATUS bit positions
localparam int STAT_IHIT     = 0;
localparam int STAT_DHIT     = 1;
localparam int STAT_STATE_LO = 2;
localparam int STAT_CNT_LO   = 8;

// FSM state encodings
localparam logic [1:0] ST_ENC_IDLE   = 2'd0;
localparam logic [1:0] ST_ENC_ARMED  = 2'd1;
localparam logic [1:0] ST_ENC_PEND   = 2'd2;
localparam logic [1:0] ST_ENC_HALTED = 2'd3;

`endif

// File: rtl/lmi_watch_ctl.sv
// LMI watchpoint controller.
// Watches instruction fetches and E-stage data accesses against
// programmable masked addresses, qualifies candidates one stage later and
// raises a registered halt request to the core. A small debug register
// file (CTRL, IADDR, IMASK, DADDR, DMASK, STATUS, THRESH) configures it.
// Optional feature macro: WATCH_HIT_CNT_EN adds an 8-bit hit counter so
// only the hit that reaches THRESH halts the core.
// Ports:
//   SYSCLK, RESET              - clock, synchronous active-high reset
//   C_IADDR_A, C_IREAD_I_N     - fetch address / active-low fetch strobe
//   IX_VAL, IX_MISS_S_R        - fetch qualifiers (one cycle later)
//   C_DADDR_E, C_DREAD_E, C_DWRITE_E, C_DBYEN_E - E-stage data access
//   DC_VAL, DC_MISS_W_R, CP0_XCPN_M - M-stage data qualifiers / exception
//   DBG_WE, DBG_RE, DBG_SEL, DATADOWNI - debug register access
//   HALT_ACK                   - core has halted
//   DATAUPI                    - registered readback data
//   WATCH_HALT_REQ             - registered halt request
module lmi_watch_ctl
    import lmi_watch_ctl_pkg::*;
(
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic [31:0] C_IADDR_A,
    input  logic        C_IREAD_I_N,
    input  logic [1:0]  IX_VAL,
    input  logic [1:0]  IX_MISS_S_R,
    input  logic [31:0] C_DADDR_E,
    input  logic        C_DREAD_E,
    input  logic        C_DWRITE_E,
    input  logic [3:0]  C_DBYEN_E,
    input  logic        DC_VAL,
    input  logic        DC_MISS_W_R,
    input  logic        CP0_XCPN_M,
    input  logic        DBG_WE,
    input  logic        DBG_RE,
    input  logic [2:0]  DBG_SEL,
    input  logic [31:0] DATADOWNI,
    input  logic        HALT_ACK,
    output logic [31:0] DATAUPI,
    output logic        WATCH_HALT_REQ
);

    logic [CTRL_W-1:0] ctrl_r;
    logic [31:0]       iaddr_r;
    logic [31:0]       imask_r;
    logic [31:0]       daddr_r;
    logic [31:0]       dmask_r;
    watch_state_e      state_r;
    logic              halt_req_r;
    logic              ihit_r;
    logic              dhit_r;
    logic              i_cand_r;
    logic              d_cand_m_r;
    logic [31:0]       dataupi_r;
`ifdef WATCH_HIT_CNT_EN
    logic [31:0]       thresh_r;
    logic [7:0]        hit_cnt_r;
    logic [7:0]        cnt_next_s;
`endif

    logic        iw_en_s;
    logic        dw_en_s;
    logic        imatch_s;
    logic        dmatch_s;
    logic        wr_ctrl_s;
    logic        resume_s;
    logic        resume_eff_s;
    logic        i_cand_e_s;
    logic        d_cand_e_s;
    logic        i_qual_s;
    logic        d_qual_s;
    logic        armed_hit_s;
    logic        halt_hit_s;
    logic [7:0]  cnt_s;
    logic [31:0] status_s;
    logic [31:0] rd_data_s;

    lmi_watch_cmp u_icmp (
        .addr  (C_IADDR_A),
        .watch (iaddr_r),
        .mask  (imask_r),
        .match (imatch_s)
    );

    lmi_watch_cmp u_dcmp (
        .addr  (C_DADDR_E),
        .watch (daddr_r),
        .mask  (dmask_r),
        .match (dmatch_s)
    );

    // Candidate formation, qualification and halt decision
    always_comb begin
        iw_en_s   = ctrl_r[CTRL_IW_EN];
        dw_en_s   = ctrl_r[CTRL_DW_EN];
        wr_ctrl_s = DBG_WE && (DBG_SEL == SEL_CTRL);
        resume_s  = wr_ctrl_s && DATADOWNI[CTRL_RESUME];
        // A RESUME landing in PEND (with or without HALT_ACK) is dropped
        // so the pending halt is never lost.
        resume_eff_s = resume_s && (state_r != ST_PEND);
        i_cand_e_s = !C_IREAD_I_N && iw_en_s && imatch_s;
        d_cand_e_s = dw_en_s
                   && ((C_DREAD_E && ctrl_r[CTRL_DW_RD]) || (C_DWRITE_E && ctrl_r[CTRL_DW_WR]))
                   && (C_DBYEN_E != 4'd0)
                   && dmatch_s;
        i_qual_s    = i_cand_r && (IX_VAL != 2'd0) && (IX_MISS_S_R == 2'd0);
        d_qual_s    = d_cand_m_r && DC_VAL && !DC_MISS_W_R && !CP0_XCPN_M;
        armed_hit_s = (state_r == ST_ARMED) && (i_qual_s || d_qual_s);
`ifdef WATCH_HIT_CNT_EN
        // Simultaneous instruction and data hits count once
        cnt_next_s = hit_cnt_r + 8'd1;
        halt_hit_s = armed_hit_s && (cnt_next_s == eff_thresh(thresh_r[7:0]));
        cnt_s      = hit_cnt_r;
`else
        halt_hit_s = armed_hit_s;
        cnt_s      = 8'd0;
`endif
    end

    // STATUS assembly and debug readback mux
    always_comb begin
        status_s                       = 32'd0;
        status_s[STAT_IHIT]            = ihit_r;
        status_s[STAT_DHIT]            = dhit_r;
        status_s[STAT_STATE_LO +: 2]   = state_r;
        status_s[STAT_CNT_LO +: 8]     = cnt_s;
        rd_data_s = 32'd0;
        case (DBG_SEL)
            SEL_CTRL:   rd_data_s = {{(32-CTRL_W){1'b0}}, ctrl_r};
            SEL_IADDR:  rd_data_s = iaddr_r;
            SEL_IMASK:  rd_data_s = imask_r;
            SEL_DADDR:  rd_data_s = daddr_r;
            SEL_DMASK:  rd_data_s = dmask_r;
            SEL_STATUS: rd_data_s = status_s;
`ifdef WATCH_HIT_CNT_EN
            SEL_THRESH: rd_data_s = thresh_r;
`else
            SEL_THRESH: rd_data_s = 32'd0;
`endif
            SEL_RSVD:   rd_data_s = 32'd0;
            default:    rd_data_s = 32'd0;
        endcase
    end

    // Debug register file writes; STATUS and reserved select are ignored
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            ctrl_r  <= {CTRL_W{1'b0}};
            iaddr_r <= 32'd0;
            imask_r <= 32'd0;
            daddr_r <= 32'd0;
            dmask_r <= 32'd0;
`ifdef WATCH_HIT_CNT_EN
            thresh_r <= 32'd0;
`endif
        end else if (DBG_WE) begin
            case (DBG_SEL)
                SEL_CTRL:   ctrl_r  <= DATADOWNI[CTRL_W-1:0];
                SEL_IADDR:  iaddr_r <= DATADOWNI;
                SEL_IMASK:  imask_r <= DATADOWNI;
                SEL_DADDR:  daddr_r <= DATADOWNI;
                SEL_DMASK:  dmask_r <= DATADOWNI;
`ifdef WATCH_HIT_CNT_EN
                SEL_THRESH: thresh_r <= DATADOWNI;
`endif
                default:    ctrl_r  <= ctrl_r;
            endcase
        end else begin
            ctrl_r <= ctrl_r;
        end
    end

    // Candidate pipeline: fetch -> qualify stage, data E -> M
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            i_cand_r   <= 1'b0;
            d_cand_m_r <= 1'b0;
        end else begin
            i_cand_r   <= i_cand_e_s;
            d_cand_m_r <= d_cand_e_s;
        end
    end

    // Watch FSM with registered halt request
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            state_r    <= ST_IDLE;
            halt_req_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    halt_req_r <= 1'b0;
                    if (iw_en_s || dw_en_s) begin
                        state_r <= ST_ARMED;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (halt_hit_s) begin
                        state_r    <= ST_PEND;
                        halt_req_r <= 1'b1;
                    end else if (!iw_en_s && !dw_en_s) begin
                        state_r    <= ST_IDLE;
                        halt_req_r <= 1'b0;
                    end else begin
                        state_r    <= ST_ARMED;
                        halt_req_r <= 1'b0;
                    end
                end
                ST_PEND: begin
                    if (HALT_ACK) begin
                        state_r    <= ST_HALTED;
                        halt_req_r <= 1'b0;
                    end else begin
                        state_r    <= ST_PEND;
                        halt_req_r <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    halt_req_r <= 1'b0;
                    // Destination follows the enables carried by the RESUME write
                    if (resume_s) begin
                        if (DATADOWNI[CTRL_IW_EN] || DATADOWNI[CTRL_DW_EN]) begin
                            state_r <= ST_ARMED;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_HALTED;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    halt_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Sticky hit flags and optional hit counter
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            ihit_r <= 1'b0;
            dhit_r <= 1'b0;
`ifdef WATCH_HIT_CNT_EN
            hit_cnt_r <= 8'd0;
`endif
        end else if (resume_eff_s) begin
            ihit_r <= 1'b0;
            dhit_r <= 1'b0;
`ifdef WATCH_HIT_CNT_EN
            hit_cnt_r <= 8'd0;
`endif
        end else if (armed_hit_s) begin
            ihit_r <= ihit_r | i_qual_s;
            dhit_r <= dhit_r | d_qual_s;
`ifdef WATCH_HIT_CNT_EN
            hit_cnt_r <= cnt_next_s;
`endif
        end else begin
            ihit_r <= ihit_r;
            dhit_r <= dhit_r;
        end
    end

    // Registered readback, held between reads
    always_ff @(posedge SYSCLK) begin
        if (RESET) begin
            dataupi_r <= 32'd0;
        end else if (DBG_RE) begin
            dataupi_r <= rd_data_s;
        end else begin
            dataupi_r <= dataupi_r;
        end
    end

    assign DATAUPI        = dataupi_r;
    assign WATCH_HALT_REQ = halt_req_r;

endmodule

// File: tb/tb_lmi_watch_ctl.sv
// Self-checking bench for lmi_watch_ctl. Expected values are pushed to a
// scoreboard queue when stimulus is driven and popped when the DUT output
// is sampled. Works with or without WATCH_HIT_CNT_EN defined.
module tb_lmi_watch_ctl;

`ifdef WATCH_HIT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        SYSCLK = 1'b0;
    logic        RESET;
    logic [31:0] C_IADDR_A;
    logic        C_IREAD_I_N;
    logic [1:0]  IX_VAL;
    logic [1:0]  IX_MISS_S_R;
    logic [31:0] C_DADDR_E;
    logic        C_DREAD_E;
    logic        C_DWRITE_E;
    logic [3:0]  C_DBYEN_E;
    logic        DC_VAL;
    logic        DC_MISS_W_R;
    logic        CP0_XCPN_M;
    logic        DBG_WE;
    logic        DBG_RE;
    logic [2:0]  DBG_SEL;
    logic [31:0] DATADOWNI;
    logic        HALT_ACK;
    logic [31:0] DATAUPI;
    logic        WATCH_HALT_REQ;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] exp_q[$];

    lmi_watch_ctl dut (
        .SYSCLK         (SYSCLK),
        .RESET          (RESET),
        .C_IADDR_A      (C_IADDR_A),
        .C_IREAD_I_N    (C_IREAD_I_N),
        .IX_VAL         (IX_VAL),
        .IX_MISS_S_R    (IX_MISS_S_R),
        .C_DADDR_E      (C_DADDR_E),
        .C_DREAD_E      (C_DREAD_E),
        .C_DWRITE_E     (C_DWRITE_E),
        .C_DBYEN_E      (C_DBYEN_E),
        .DC_VAL         (DC_VAL),
        .DC_MISS_W_R    (DC_MISS_W_R),
        .CP0_XCPN_M     (CP0_XCPN_M),
        .DBG_WE         (DBG_WE),
        .DBG_RE         (DBG_RE),
        .DBG_SEL        (DBG_SEL),
        .DATADOWNI      (DATADOWNI),
        .HALT_ACK       (HALT_ACK),
        .DATAUPI        (DATAUPI),
        .WATCH_HALT_REQ (WATCH_HALT_REQ)
    );

    always #5 SYSCLK = ~SYSCLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled here too
    task automatic tick();
        @(posedge SYSCLK);
        #1;
    endtask

    task automatic sb_pop_check(input string tag, input logic [31:0] got);
        if (exp_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            check_val(tag, got, exp_q.pop_front());
        end
    endtask

    task automatic dbg_wr(input logic [2:0] sel, input logic [31:0] data);
        DBG_WE = 1'b1; DBG_SEL = sel; DATADOWNI = data;
        tick();
        DBG_WE = 1'b0; DATADOWNI = 32'd0;
    endtask

    task automatic dbg_rd(input string tag, input logic [2:0] sel, input logic [31:0] exp);
        exp_q.push_back(exp);
        DBG_RE = 1'b1; DBG_SEL = sel;
        tick();
        DBG_RE = 1'b0;
        sb_pop_check(tag, DATAUPI);
    endtask

    task automatic halt_chk(input string tag, input logic exp);
        exp_q.push_back({31'd0, exp});
        sb_pop_check(tag, {31'd0, WATCH_HALT_REQ});
    endtask

    // One fetch cycle followed by its qualifier cycle
    task automatic fetch(input logic [31:0] addr, input logic [1:0] val, input logic [1:0] miss);
        C_IREAD_I_N = 1'b0; C_IADDR_A = addr;
        tick();
        C_IREAD_I_N = 1'b1; IX_VAL = val; IX_MISS_S_R = miss;
        tick();
        IX_VAL = 2'd0; IX_MISS_S_R = 2'd0;
    endtask

    // One E-stage data access followed by its M-stage qualifier cycle
    task automatic daccess(input logic rd, input logic wr, input logic [3:0] byen,
                           input logic dval, input logic dmiss, input logic xcpn);
        C_DADDR_E = 32'hA000_004C; C_DREAD_E = rd; C_DWRITE_E = wr; C_DBYEN_E = byen;
        tick();
        C_DREAD_E = 1'b0; C_DWRITE_E = 1'b0; C_DBYEN_E = 4'd0;
        DC_VAL = dval; DC_MISS_W_R = dmiss; CP0_XCPN_M = xcpn;
        tick();
        DC_VAL = 1'b0; DC_MISS_W_R = 1'b0; CP0_XCPN_M = 1'b0;
    endtask

    task automatic ack();
        HALT_ACK = 1'b1;
        tick();
        HALT_ACK = 1'b0;
    endtask

    initial begin
        RESET = 1'b1; C_IADDR_A = 32'd0; C_IREAD_I_N = 1'b1; IX_VAL = 2'd0; IX_MISS_S_R = 2'd0;
        C_DADDR_E = 32'd0; C_DREAD_E = 1'b0; C_DWRITE_E = 1'b0; C_DBYEN_E = 4'd0;
        DC_VAL = 1'b0; DC_MISS_W_R = 1'b0; CP0_XCPN_M = 1'b0;
        DBG_WE = 1'b0; DBG_RE = 1'b0; DBG_SEL = 3'd0; DATADOWNI = 32'd0; HALT_ACK = 1'b0;
        tick(); tick();
        RESET = 1'b0;

        // Reset state
        halt_chk("rst_halt", 1'b0);
        check_val("rst_dataupi", DATAUPI, 32'd0);
        dbg_rd("rst_ctrl", 3'd0, 32'd0);
        dbg_rd("rst_status", 3'd5, 32'd0);

        // Instruction hit
        dbg_wr(3'd1, 32'h8000_1000);
        dbg_wr(3'd2, 32'd0);
        dbg_wr(3'd0, 32'h0000_0001);
        tick();
        dbg_rd("armed_status", 3'd5, 32'h0000_0004);
        dbg_rd("iaddr_rb", 3'd1, 32'h8000_1000);
        dbg_wr(3'd5, 32'hFFFF_FFFF);
        dbg_rd("status_ro", 3'd5, 32'h0000_0004);
        dbg_rd("sel7_rb", 3'd7, 32'd0);
        C_IREAD_I_N = 1'b0; C_IADDR_A = 32'h8000_1000;
        tick();
        C_IREAD_I_N = 1'b1; IX_VAL = 2'b01;
        halt_chk("ihit_cyc1", 1'b0);
        tick();
        IX_VAL = 2'b00;
        halt_chk("ihit_cyc2", 1'b1);
        tick();
        halt_chk("pend_hold", 1'b1);
        ack();
        halt_chk("halted_req", 1'b0);
        dbg_rd("ihit_status", 3'd5, CNT_EN ? 32'h0000_010D : 32'h0000_000D);

        // Resume back to ARMED clears the hit bits
        dbg_wr(3'd0, 32'h0000_0103);
        dbg_rd("resume_armed", 3'd5, 32'h0000_0004);
        dbg_rd("resume_ctrl", 3'd0, 32'h0000_0003);

        // Masked data write
        dbg_wr(3'd3, 32'hA000_0040);
        dbg_wr(3'd4, 32'h0000_000F);
        dbg_wr(3'd0, 32'h0000_000A);
        daccess(1'b1, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0);
        halt_chk("dread_nohit", 1'b0);
        daccess(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);
        halt_chk("dbyen0_nohit", 1'b0);
        daccess(1'b0, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        halt_chk("dwrite_hit", 1'b1);
        ack();
        dbg_rd("dhit_status", 3'd5, CNT_EN ? 32'h0000_010E : 32'h0000_000E);

        // Resume with enables cleared -> IDLE
        dbg_wr(3'd0, 32'h0000_0100);
        dbg_rd("resume_idle", 3'd5, 32'd0);
        dbg_rd("resume_idle_ctrl", 3'd0, 32'd0);

        // Exception squash and cache miss on data reads
        dbg_wr(3'd0, 32'h0000_0006);
        tick();
        daccess(1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 1'b1);
        halt_chk("xcpn_squash", 1'b0);
        daccess(1'b1, 1'b0, 4'b1111, 1'b1, 1'b1, 1'b0);
        halt_chk("dmiss_drop", 1'b0);
        dbg_rd("squash_status", 3'd5, 32'h0000_0004);

        // Instruction candidates dropped by miss / no valid
        dbg_wr(3'd0, 32'h0000_0001);
        fetch(32'h8000_1000, 2'b01, 2'b01);
        halt_chk("imiss_drop", 1'b0);
        fetch(32'h8000_1000, 2'b00, 2'b00);
        halt_chk("ival0_drop", 1'b0);
        fetch(32'h8000_1004, 2'b10, 2'b00);
        halt_chk("iaddr_nomatch", 1'b0);

        // Hit counter threshold
        dbg_wr(3'd6, 32'h0000_0003);
        dbg_rd("thresh_rb", 3'd6, CNT_EN ? 32'h0000_0003 : 32'd0);
        for (int k = 1; k <= 3; k++) begin
            fetch(32'h8000_1000, 2'b10, 2'b00);
            halt_chk($sformatf("cnt_fetch%0d", k), CNT_EN ? (k == 3) : 1'b1);
        end

        // HALT_ACK and RESUME together in PEND: halt wins
        HALT_ACK = 1'b1;
        dbg_wr(3'd0, 32'h0000_0103);
        HALT_ACK = 1'b0;
        halt_chk("ack_resume_req", 1'b0);
        dbg_rd("ack_resume_status", 3'd5, CNT_EN ? 32'h0000_030D : 32'h0000_000D);

        // Reset while PEND
        dbg_wr(3'd6, 32'h0000_0001);
        dbg_wr(3'd0, 32'h0000_0101);
        dbg_rd("rearm_status", 3'd5, 32'h0000_0004);
        fetch(32'h8000_1000, 2'b01, 2'b00);
        halt_chk("pre_reset_req", 1'b1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        halt_chk("reset_pend_req", 1'b0);
        check_val("reset_dataupi", DATAUPI, 32'd0);
        dbg_rd("reset_status", 3'd5, 32'd0);
        dbg_rd("reset_ctrl", 3'd0, 32'd0);
        dbg_rd("reset_iaddr", 3'd1, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
